// File: rtl/escritura_status_rtc.sv
// escritura_status_rtc: writes the latched status byte to the RTC status
// register over a multiplexed address/data bus. The write has an address
// phase followed by a data phase, and each phase runs setup, strobe and hold.
//
// Ports:
//   reloj                - clock; all logic is on its rising edge
//   resetM               - synchronous reset, active high
//   Mod_s[7:0]           - status byte, latched when a transaction starts
//   enable_status_crono  - request from the status stage
//   enable_status_fh     - request from the status stage
//   AD_out[7:0]          - multiplexed address/data bus value
//   AD_oe                - pad output enable (1 = drive)
//   A_D                  - 0 = address phase, 1 = data phase
//   CS_n, WR_n, RD_n     - RTC strobes, active low (RD_n is held at 1)
//   busy                 - transaction in progress
//   done                 - one-cycle pulse on completion
module escritura_status_rtc #(
  parameter logic [7:0]  ADDR_STATUS = 8'h00,
  parameter int unsigned T_SU        = 2,
  parameter int unsigned T_PW        = 4,
  parameter int unsigned T_H         = 2
) (
  input  logic       reloj,
  input  logic       resetM,
  input  logic [7:0] Mod_s,
  input  logic       enable_status_crono,
  input  logic       enable_status_fh,
  output logic [7:0] AD_out,
  output logic       AD_oe,
  output logic       A_D,
  output logic       CS_n,
  output logic       WR_n,
  output logic       RD_n,
  output logic       busy,
  output logic       done
);

  localparam int unsigned T_MAX = (T_SU > T_PW) ? ((T_SU > T_H) ? T_SU : T_H)
                                                : ((T_PW > T_H) ? T_PW : T_H);
  localparam int unsigned CW    = $clog2(T_MAX) + 1;

  // A zero-length phase cannot be timed by the counter.
  if (T_SU == 0 || T_PW == 0 || T_H == 0) begin : g_bad_timing
    $error("escritura_status_rtc: T_SU, T_PW and T_H must all be >= 1");
  end

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    A_SU = 3'd1,
    A_PW = 3'd2,
    A_H  = 3'd3,
    D_SU = 3'd4,
    D_PW = 3'd5,
    D_H  = 3'd6,
    DONE = 3'd7
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, dur;
  logic          req, req_q, start, last;
  logic [7:0]    byte_q;

  // Next-value signals for the registered outputs
  logic [7:0] ad_out_n;
  logic       ad_oe_n, a_d_n, strobe_n, busy_n, done_n;

  assign req   = enable_status_crono | enable_status_fh;
  assign start = req & ~req_q;

  // Duration of the current phase state; last cycle when the counter reaches it.
  always_comb begin
    dur = CW'(1);
    case (state)
      A_SU, D_SU: dur = CW'(T_SU);
      A_PW, D_PW: dur = CW'(T_PW);
      A_H,  D_H:  dur = CW'(T_H);
      default:    dur = CW'(1);
    endcase
    last = (cnt == dur - CW'(1));
  end

  // Next-state logic; outputs are decoded from the state being entered.
  always_comb begin
    state_n  = state;
    ad_out_n = 8'h00;
    ad_oe_n  = 1'b0;
    a_d_n    = 1'b0;
    strobe_n = 1'b0;
    busy_n   = 1'b0;
    done_n   = 1'b0;

    case (state)
      IDLE:    if (start) state_n = A_SU;
      A_SU:    if (last)  state_n = A_PW;
      A_PW:    if (last)  state_n = A_H;
      A_H:     if (last)  state_n = D_SU;
      D_SU:    if (last)  state_n = D_PW;
      D_PW:    if (last)  state_n = D_H;
      D_H:     if (last)  state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    case (state_n)
      A_SU, A_PW, A_H: begin
        ad_out_n = ADDR_STATUS;
        ad_oe_n  = 1'b1;
        busy_n   = 1'b1;
        strobe_n = (state_n == A_PW);
      end
      D_SU, D_PW, D_H: begin
        // On the IDLE->A_SU edge Mod_s is latched, so byte_q is valid here.
        ad_out_n = byte_q;
        ad_oe_n  = 1'b1;
        a_d_n    = 1'b1;
        busy_n   = 1'b1;
        strobe_n = (state_n == D_PW);
      end
      DONE: begin
        // Bus released; address/data lines keep their last value.
        ad_out_n = byte_q;
        a_d_n    = 1'b1;
        busy_n   = 1'b1;
        done_n   = 1'b1;
      end
      default: begin
        ad_out_n = 8'h00;
      end
    endcase
  end

  // State, counter, request edge and byte latch
  always_ff @(posedge reloj) begin
    if (resetM) begin
      state  <= IDLE;
      cnt    <= '0;
      req_q  <= 1'b0;
      byte_q <= 8'h00;
    end else begin
      state <= state_n;
      req_q <= req;
      cnt   <= (state_n != state) ? '0 : cnt + CW'(1);
      if (state == IDLE && start) byte_q <= Mod_s;
    end
  end

  // Registered outputs
  always_ff @(posedge reloj) begin
    if (resetM) begin
      AD_out <= 8'h00;
      AD_oe  <= 1'b0;
      A_D    <= 1'b0;
      CS_n   <= 1'b1;
      WR_n   <= 1'b1;
      RD_n   <= 1'b1;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      AD_out <= ad_out_n;
      AD_oe  <= ad_oe_n;
      A_D    <= a_d_n;
      CS_n   <= ~strobe_n;
      WR_n   <= ~strobe_n;
      RD_n   <= 1'b1;
      busy   <= busy_n;
      done   <= done_n;
    end
  end

endmodule

// File: tb/tb_escritura_status_rtc.sv
// Testbench for escritura_status_rtc: directed scenarios plus random traffic,
// checked every cycle against a cycle-index reference model.
module tb_escritura_status_rtc;

  localparam logic [7:0]  ADDR  = 8'h00;
  localparam int unsigned T_SU  = 2;
  localparam int unsigned T_PW  = 4;
  localparam int unsigned T_H   = 2;
  localparam int          PH    = T_SU + T_PW + T_H;
  localparam int          TOTAL = 2 * PH + 1;

  logic       reloj = 1'b0;
  logic       resetM = 1'b1;
  logic [7:0] Mod_s = 8'h00;
  logic       crono = 1'b0;
  logic       fh = 1'b0;
  logic [7:0] AD_out;
  logic       AD_oe, A_D, CS_n, WR_n, RD_n, busy, done;

  int checks = 0;
  int errors = 0;

  escritura_status_rtc #(
    .ADDR_STATUS(ADDR), .T_SU(T_SU), .T_PW(T_PW), .T_H(T_H)
  ) dut (
    .reloj(reloj), .resetM(resetM), .Mod_s(Mod_s),
    .enable_status_crono(crono), .enable_status_fh(fh),
    .AD_out(AD_out), .AD_oe(AD_oe), .A_D(A_D), .CS_n(CS_n), .WR_n(WR_n),
    .RD_n(RD_n), .busy(busy), .done(done)
  );

  always #5 reloj = ~reloj;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: m_k is the cycle index within a transaction (0 = idle).
  int         m_k = 0;
  logic [7:0] m_byte = 8'h00;
  logic       m_req_q = 1'b0;

  always @(posedge reloj) begin
    logic req;
    req = crono | fh;
    if (resetM) begin
      m_k = 0; m_req_q = 1'b0; m_byte = 8'h00;
    end else begin
      if (m_k == 0 && req && !m_req_q) begin
        m_k = 1; m_byte = Mod_s;
      end else if (m_k == TOTAL) m_k = 0;
      else if (m_k > 0) m_k++;
      m_req_q = req;
    end
  end

  // Per-cycle comparison on the falling edge
  bit started = 1'b0;
  int busy_run = 0;
  int done_cnt = 0;

  always @(negedge reloj) begin
    int         p;
    logic       strobe;
    logic [7:0] e_ad;
    logic [6:0] e_ctl;
    if (started) begin
      p      = (m_k >= 1 && m_k <= 2 * PH) ? (m_k - 1) % PH : -1;
      strobe = (p >= T_SU) && (p < T_SU + T_PW);
      e_ad   = (m_k == 0) ? 8'h00 : (m_k <= PH) ? ADDR : m_byte;
      // {AD_oe, A_D, CS_n, WR_n, RD_n, busy, done}
      e_ctl  = {(m_k >= 1 && m_k <= 2 * PH), (m_k > PH), !strobe, !strobe,
                1'b1, (m_k > 0), (m_k == TOTAL)};
      check("ad_out", 32'(AD_out), 32'(e_ad));
      check("ctl", 32'({AD_oe, A_D, CS_n, WR_n, RD_n, busy, done}), 32'(e_ctl));
      busy_run = busy ? busy_run + 1 : 0;
      if (done) begin
        done_cnt++;
        check("busy_len", 32'(busy_run), 32'(TOTAL));
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge reloj); #1; end
  endtask

  task automatic wait_k(input int target);
    int n = 0;
    while (m_k != target && n < 200) begin tick(); n++; end
    check("wait_k", 32'(m_k), 32'(target));
  endtask

  initial begin
    int d0;
    // Reset with enables toggling
    resetM = 1'b1;
    tick();
    started = 1'b1;
    for (int i = 0; i < 3; i++) begin
      crono = 1'(i); fh = 1'(~i); Mod_s = 8'($urandom);
      tick();
    end
    crono = 1'b0; fh = 1'b0;
    resetM = 1'b0;
    tick(2);

    // Basic write
    Mod_s = 8'h18; crono = 1'b1; tick(); crono = 1'b0; Mod_s = 8'h00;
    check("first_cycle_oe", 32'({AD_oe, A_D, AD_out}), 32'({1'b1, 1'b0, ADDR}));
    wait_k(10);
    check("data_byte", 32'({A_D, AD_out}), 32'({1'b1, 8'h18}));
    wait_k(0);
    tick(2);

    // Level hold: one transaction only, then retrigger after idle
    d0 = done_cnt;
    fh = 1'b1; tick(40);
    check("level_one_txn", 32'(done_cnt - d0), 32'd1);
    fh = 1'b0; tick(3);
    fh = 1'b1; tick(); fh = 1'b0;
    wait_k(0);
    check("retrigger", 32'(done_cnt - d0), 32'd2);
    tick(2);

    // Busy collision
    Mod_s = 8'h08; crono = 1'b1; tick(); crono = 1'b0;
    wait_k(6);
    crono = 1'b1; Mod_s = 8'h10; tick(); crono = 1'b0;
    wait_k(10);
    check("collision_data", 32'(AD_out), 32'h08);
    wait_k(0);
    tick(3);

    // Simultaneous requests
    d0 = done_cnt;
    Mod_s = 8'h18; crono = 1'b1; fh = 1'b1; tick(); crono = 1'b0; fh = 1'b0;
    wait_k(0); tick(5);
    check("simul_one_txn", 32'(done_cnt - d0), 32'd1);

    // Request landing in the DONE cycle is ignored
    d0 = done_cnt;
    Mod_s = 8'h5A; crono = 1'b1; tick(); crono = 1'b0;
    wait_k(TOTAL);
    crono = 1'b1; tick(6);
    check("done_collision_idle", 32'(busy), 32'd0);
    crono = 1'b0; tick(2);
    check("done_collision_cnt", 32'(done_cnt - d0), 32'd1);

    // Reset during data strobe
    d0 = done_cnt;
    Mod_s = 8'hC3; fh = 1'b1; tick(); fh = 1'b0;
    wait_k(PH + T_SU + 2);
    check("mid_cs_low", 32'(CS_n), 32'd0);
    resetM = 1'b1; tick(); resetM = 1'b0;
    check("mid_reset", 32'({CS_n, WR_n, AD_oe, busy}), 32'({1'b1, 1'b1, 1'b0, 1'b0}));
    tick(25);
    check("mid_no_done", 32'(done_cnt - d0), 32'd0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      crono  = ($urandom % 8) == 0;
      fh     = ($urandom % 12) == 0;
      Mod_s  = 8'($urandom);
      resetM = ($urandom % 400) == 0;
      tick();
    end
    resetM = 1'b0; crono = 1'b0; fh = 1'b0;
    tick(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/escritura_status_rtc.md
Name: escritura_status_rtc

Overview:
- Bus-write sequencer directly downstream of the status-modify stage.
- Latches the 8-bit status byte Mod_s when either status enable pulses.
- Writes the byte to the RTC's status register over the multiplexed address/data bus as two phases: address write, then data write.
- Generates the chip-select, write-strobe and address/data-select timing in clock cycles. Asserts busy for the whole transaction and pulses done once at the end.

Parameters:
- ADDR_STATUS, 8'h00, RTC status register address driven during the address phase.
- T_SU, 2, setup cycles per phase: bus and A_D valid, strobes inactive.
- T_PW, 4, strobe cycles per phase: CS_n=0 and WR_n=0.
- T_H, 2, hold cycles per phase: strobes inactive, bus still driven.

Ports:
- reloj  input  1  system clock; all logic on its rising edge.
- resetM  input  1  synchronous reset, active high.
- Mod_s  input  8  status byte to write; sampled only at start.
- enable_status_crono  input  1  request from status stage (chronometer bit).
- enable_status_fh  input  1  request from status stage (12/24h format bit).
- AD_out  output  8  multiplexed address/data bus value.
- AD_oe  output  1  bus output enable to the tristate pad (1 = drive).
- A_D  output  1  0 = address phase, 1 = data phase.
- CS_n  output  1  RTC chip select, active low.
- WR_n  output  1  RTC write strobe, active low.
- RD_n  output  1  RTC read strobe; held at 1 (write-only block).
- busy  output  1  transaction in progress.
- done  output  1  one-cycle pulse on completion.

Behaviour:
- Interface: one clock, reloj. Reset resetM is synchronous, active high.
- All outputs are registered.
- Reset values: AD_out=8'h00, AD_oe=0, A_D=0, CS_n=1, WR_n=1, RD_n=1, busy=0, done=0. Internal state: state=IDLE, counter=0, edge register=0, latched byte=0.
- Request: req = enable_status_crono | enable_status_fh. A registered copy req_q is updated every cycle, including while busy. Start = req & ~req_q, i.e. rising edge only; a level held high does not retrigger.
- States: IDLE, A_SU, A_PW, A_H, D_SU, D_PW, D_H, DONE.
- IDLE -> A_SU on start.
  - Same edge: latch Mod_s, busy=1, AD_oe=1, A_D=0, AD_out=ADDR_STATUS.
  - First bus-driven cycle is therefore the cycle after start is seen.
- A_SU: lasts T_SU cycles; CS_n=1, WR_n=1. Then A_PW.
- A_PW: lasts T_PW cycles; CS_n=0, WR_n=0. Then A_H.
- A_H: lasts T_H cycles; CS_n=1, WR_n=1; AD_out unchanged. Then D_SU.
- D_SU: on entry A_D=1 and AD_out=latched byte. Same timing as A_SU, then D_PW.
- D_PW: same timing as A_PW, then D_H.
- D_H: same timing as A_H, then DONE.
- DONE: one cycle.
  - done=1, busy=1, AD_oe=0, CS_n=1, WR_n=1.
  - Next edge: IDLE with done=0, busy=0, A_D=0, AD_out=8'h00.
- Phase counter: clog2(max(T_SU,T_PW,T_H))+1 bits. Cleared on every state change. Each state exits when counter == duration-1.
- Total transaction: 2*(T_SU+T_PW+T_H)+1 cycles of busy; 17 with the defaults.
- AD_out and A_D change only on SU-state entry, never while CS_n=0.
- Invariant: CS_n and WR_n are always equal.
- Start while busy (not IDLE) is ignored and not queued.
- Both enables rising in the same cycle start a single transaction.
- Mod_s changing mid-transaction has no effect; the latched byte is used.
- Start arriving in the same cycle as DONE is ignored; only a new rising edge after return to IDLE starts a transaction.
- resetM asserted mid-transaction: the next edge returns every output and state to its reset value; no partial strobe is completed.
- Parameters must be ≥1. A value of 0 is illegal; flag it with an elaboration-time check.

Test Plan:
- Reset: hold resetM 3 cycles with enables toggling -> all outputs stay at reset values, busy=0, no CS_n low.
- Basic write: Mod_s=8'h18, pulse enable_status_crono 1 cycle with defaults ->
  - Next cycle AD_oe=1, A_D=0, AD_out=8'h00.
  - CS_n/WR_n low for exactly 4 cycles in each phase.
  - Data phase AD_out=8'h18, A_D=1.
  - done high on busy's 17th cycle; busy low the cycle after.
- Level hold / retrigger: enable_status_fh held high 40 cycles -> exactly one transaction. Drop the enable, raise it again after idle -> second transaction.
- Busy collision: second enable_status_crono rise and Mod_s=8'h10 at busy cycle 6 -> ignored; data phase still writes the first latched value, 8'h08.
- Simultaneous requests: both enables rise same cycle, Mod_s=8'h18 -> one transaction, 17 busy cycles.
- Reset mid-op: resetM asserted during D_PW (CS_n=0) -> next edge CS_n=1, WR_n=1, AD_oe=0, busy=0, done never pulses.
